// File: rtl/led_share_arbiter.sv
// Round-robin arbiter sharing an 8-bit LED bank between N_REQ pattern sources,
// with tick-based min/max hold times and a bouncing-bar idle pattern.
module led_share_arbiter #(
    parameter int N_REQ     = 3,
    parameter int TICK_DIV  = 15000000,
    parameter int MIN_TICKS = 2,
    parameter int MAX_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   pat,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic [7:0]           oled
);

    localparam int IW = $clog2(N_REQ);
    localparam int DW = $clog2(TICK_DIV);
    localparam int HW = $clog2(MAX_TICKS + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HELD_MIN   = HW'(MIN_TICKS);
    localparam logic [HW-1:0] HELD_MAX   = HW'(MAX_TICKS);
    localparam logic [IW-1:0] OWNER_LAST = IW'(N_REQ - 1);

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [IW-1:0]    start);
        logic [IW:0]   sum;
        logic          found;
        logic [IW-1:0] idx;
        found = 1'b0;
        idx   = start;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end else begin
                sum = sum;
            end
            if (r[sum[IW-1:0]]) begin
                found = 1'b1;
                idx   = sum[IW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [0:0]       state_q,    state_d;
    logic [IW-1:0]    owner_q,    owner_d;
    logic [HW-1:0]    held_q,     held_d;
    logic [IW-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [7:0]       idle_q,     idle_d;
    logic             dir_q,      dir_d;
    logic [7:0]       last_pat_q, last_pat_d;
    logic [DW-1:0]    div_cnt_q,  div_cnt_d;
    logic [7:0]       oled_q,     oled_d;
    logic [N_REQ-1:0] gnt_q,      gnt_d;
    logic             busy_q,     busy_d;

    logic             tick_s;
    logic             owner_req_s;
    logic [7:0]       owner_pat_s;
    logic [N_REQ-1:0] others_s;
    logic [IW-1:0]    rr_next_s;
    logic [IW:0]      idle_pick_s;
    logic [IW:0]      rot_pick_s;
    logic [7:0]       idle_step_s;
    logic             dir_step_s;
    logic             release_s;
    logic             rotate_s;

    // Free-running display tick divider.
    always_comb begin
        tick_s = (div_cnt_q == DIV_LAST);
        if (tick_s) begin
            div_cnt_d = {DW{1'b0}};
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    // Owner-related helpers and the next bouncing-bar step.
    always_comb begin
        owner_req_s = req[owner_q];
        // A dropped request keeps showing the last pattern captured for this owner.
        if (owner_req_s) begin
            owner_pat_s = pat[{owner_q, 3'b000} +: 8];
        end else begin
            owner_pat_s = last_pat_q;
        end
        others_s          = req;
        others_s[owner_q] = 1'b0;
        if (owner_q == OWNER_LAST) begin
            rr_next_s = {IW{1'b0}};
        end else begin
            rr_next_s = owner_q + IW'(1);
        end
        idle_pick_s = rr_pick(req, rr_ptr_q);
        rot_pick_s  = rr_pick(others_s, rr_next_s);
        release_s   = !owner_req_s && (held_q >= HELD_MIN);
        rotate_s    = (held_q == HELD_MAX) && (|others_s);
        if (dir_q) begin
            idle_step_s = {idle_q[6:0], 1'b1};
            dir_step_s  = (idle_q == 8'h7F) ? 1'b0 : 1'b1;
        end else begin
            idle_step_s = {1'b0, idle_q[7:1]};
            dir_step_s  = (idle_q == 8'h01) ? 1'b1 : 1'b0;
        end
    end

    // Arbitration state machine and output next-state.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        held_d     = held_q;
        rr_ptr_d   = rr_ptr_q;
        idle_d     = idle_q;
        dir_d      = dir_q;
        last_pat_d = last_pat_q;
        oled_d     = oled_q;
        case (state_q)
            ST_IDLE: begin
                if (idle_pick_s[IW]) begin
                    state_d    = ST_GRANT;
                    owner_d    = idle_pick_s[IW-1:0];
                    held_d     = {HW{1'b0}};
                    last_pat_d = pat[{idle_pick_s[IW-1:0], 3'b000} +: 8];
                end else if (tick_s) begin
                    idle_d = idle_step_s;
                    dir_d  = dir_step_s;
                    oled_d = idle_step_s;
                end else begin
                    oled_d = idle_q;
                end
            end
            ST_GRANT: begin
                oled_d     = owner_pat_s;
                last_pat_d = owner_pat_s;
                if (release_s || rotate_s) begin
                    rr_ptr_d = rr_next_s;
                    if (rot_pick_s[IW]) begin
                        owner_d    = rot_pick_s[IW-1:0];
                        held_d     = {HW{1'b0}};
                        last_pat_d = pat[{rot_pick_s[IW-1:0], 3'b000} +: 8];
                    end else begin
                        state_d = ST_IDLE;
                        oled_d  = idle_q;
                    end
                end else if (tick_s && (held_q != HELD_MAX)) begin
                    held_d = held_q + HW'(1);
                end else begin
                    held_d = held_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_GRANT) begin
            gnt_d = onehot(owner_d);
        end else begin
            gnt_d = {N_REQ{1'b0}};
        end
        busy_d = (state_d == ST_GRANT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= {IW{1'b0}};
            held_q     <= {HW{1'b0}};
            rr_ptr_q   <= {IW{1'b0}};
            idle_q     <= 8'h00;
            dir_q      <= 1'b1;
            last_pat_q <= 8'h00;
            div_cnt_q  <= {DW{1'b0}};
            oled_q     <= 8'h00;
            gnt_q      <= {N_REQ{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            held_q     <= held_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_q     <= idle_d;
            dir_q      <= dir_d;
            last_pat_q <= last_pat_d;
            div_cnt_q  <= div_cnt_d;
            oled_q     <= oled_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign oled = oled_q;

endmodule
